// File: rtl/drops_bist_pkg.sv
// Shared types and constant tables for the drops BIST harness.
// Latency: none (types and constant functions only).
// Backpressure: none.
package drops_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  // Maximal-length tap masks for a left-shifting Fibonacci LFSR whose new LSB
  // is the parity of (state & taps); the top bit is always part of the mask.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  // Low-order terms of a primitive polynomial per width (x^w term implicit).
  function automatic logic [15:0] misr_poly(input int w);
    case (w)
      4:       return 16'h0003;
      5:       return 16'h0005;
      6:       return 16'h0003;
      7:       return 16'h0003;
      8:       return 16'h001D;
      9:       return 16'h0011;
      10:      return 16'h0009;
      11:      return 16'h0005;
      12:      return 16'h0053;
      13:      return 16'h001B;
      14:      return 16'h002B;
      15:      return 16'h0003;
      16:      return 16'h002D;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/drops_bist_misr.sv
// Multiple-input signature register compacting core responses.
// Latency: one cycle from an enabled sample to the updated signature.
// Backpressure: none; samples every cycle en is high, clr has priority.
module drops_bist_misr
  import drops_bist_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam logic [15:0]  POLY_FULL = misr_poly(W);
  localparam logic [W-1:0] POLY      = POLY_FULL[W-1:0];

  // Shift left, reduce by the polynomial on carry-out, then fold in the sample.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ d;
    end
  end

endmodule

// File: rtl/drops_bist.sv
// LFSR-stimulus / MISR-response self-test harness for the drops core (optional GOLDEN compare: DROPS_BIST_COMPARE_EN).
// Latency: done rises N_VEC+LAT+1 cycles after the start edge; signature final on that cycle.
// Backpressure: none; start is ignored while busy, rst aborts a run immediately.
module drops_bist
  import drops_bist_pkg::*;
#(
  parameter int          W_IN   = 8,
  parameter int          W_OUT  = 8,
  parameter int          N_VEC  = 255,
  parameter int          LAT    = 1,
  parameter logic [15:0] SEED   = 16'd1,
  parameter logic [15:0] GOLDEN = 16'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_OUT-1:0] resp_i,
  output logic [W_IN-1:0]  stim_o,
  output logic             stim_valid,
  output logic             busy,
  output logic             done,
  output logic [W_OUT-1:0] signature,
  output logic             pass
);

  localparam logic [15:0]     TAPS_FULL  = lfsr_taps(W_IN);
  localparam logic [W_IN-1:0] TAPS       = TAPS_FULL[W_IN-1:0];
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [W_IN-1:0] SEED_EFF   = (SEED[W_IN-1:0] == '0) ?
                                           {{(W_IN-1){1'b0}}, 1'b1} : SEED[W_IN-1:0];
  localparam logic [15:0]     LAST_VEC   = 16'(N_VEC - 1);
  localparam logic [15:0]     LAST_FLUSH = 16'((LAT > 0) ? LAT - 1 : 0);

  bist_state_t     state;
  logic [15:0]     cnt;
  logic [W_IN-1:0] lfsr;
  logic [W_IN-1:0] lfsr_nxt;
  logic            cap;
  logic            misr_clr;

  assign lfsr_nxt = {lfsr[W_IN-2:0], ^(lfsr & TAPS)};
  assign misr_clr = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign stim_o   = stim_valid ? lfsr : '0;

  // Run control: one counter serves both the vector count and the flush wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lfsr       <= SEED_EFF;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            cnt        <= '0;
            lfsr       <= SEED_EFF;
            stim_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_RUN: begin
          lfsr <= lfsr_nxt;
          if (cnt == LAST_VEC) begin
            cnt        <= '0;
            stim_valid <= 1'b0;
            if (LAT > 0) begin
              state <= ST_FLUSH;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_FLUSH: begin
          if (cnt == LAST_FLUSH) begin
            cnt   <= '0;
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  if (LAT == 0) begin : g_cap_direct
    assign cap = stim_valid;
  end else begin : g_cap_pipe
    logic [LAT-1:0] cap_pipe;

    // Delay stim_valid by the core latency so responses line up with vectors.
    always_ff @(posedge clk) begin
      if (rst) begin
        cap_pipe <= '0;
      end else begin
        cap_pipe[0] <= stim_valid;
        for (int i = 1; i < LAT; i++) begin
          cap_pipe[i] <= cap_pipe[i-1];
        end
      end
    end

    assign cap = cap_pipe[LAT-1];
  end

  drops_bist_misr #(
    .W (W_OUT)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (cap),
    .d   (resp_i),
    .q   (signature)
  );

`ifdef DROPS_BIST_COMPARE_EN
  assign pass = done && (signature == GOLDEN[W_OUT-1:0]);
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_drops_bist.sv
module tb_drops_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_abort;
  logic       start_a, start_b, start_c;
  logic [7:0] resp_a, resp_b, resp_c;
  logic [7:0] stim_a, stim_b, stim_c;
  logic       sv_a, sv_b, sv_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] sig_a, sig_b, sig_c;
  logic       pass_a, pass_b, pass_c;

  int checks = 0;
  int errors = 0;

  logic [7:0] ra [0:300];
  logic [7:0] rc [0:31];
  logic [7:0] known [0:5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

  always #5 clk = ~clk;

  // Reference LFSR: shift left, new LSB = parity of tapped bits (mask 0xB8).
  function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
    return {s[6:0], 1'($countones(s & 8'hB8) % 2)};
  endfunction

  // Reference MISR: multiply by x modulo x^8+x^4+x^3+x^2+1, then add sample.
  function automatic logic [7:0] ref_misr(input logic [7:0] s, input logic [7:0] d);
    logic [8:0] t;
    t = {s, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0] ^ d;
  endfunction

  function automatic logic [7:0] fixed_resp(input int k);
    return 8'(90 + k * 13);
  endfunction

  function automatic logic [7:0] fixed_gold();
    logic [7:0] s;
    logic [8:0] t;
    s = 8'h00;
    for (int k = 4; k < 8; k++) begin
      t = {s, 1'b0};
      if (t[8]) t = t ^ 9'h11D;
      s = t[7:0] ^ fixed_resp(k);
    end
    return s;
  endfunction

  localparam logic [7:0] GOLD_C = fixed_gold();

  drops_bist #(.W_IN(8), .W_OUT(8), .N_VEC(255), .LAT(1), .SEED(16'd1), .GOLDEN(16'd0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .resp_i(resp_a), .stim_o(stim_a),
    .stim_valid(sv_a), .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a));

  drops_bist #(.W_IN(8), .W_OUT(8), .N_VEC(2), .LAT(0), .SEED(16'd0), .GOLDEN(16'd0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .resp_i(resp_b), .stim_o(stim_b),
    .stim_valid(sv_b), .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b));

  drops_bist #(.W_IN(8), .W_OUT(8), .N_VEC(4), .LAT(3), .SEED(16'd1), .GOLDEN({8'h00, GOLD_C})) u_c (
    .clk(clk), .rst(rst || rst_abort), .start(start_c), .resp_i(resp_c), .stim_o(stim_c),
    .stim_valid(sv_c), .busy(busy_c), .done(done_c), .signature(sig_c), .pass(pass_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected u_c signature: captures occupy cycles t+4..t+7.
  function automatic logic [7:0] model_c();
    logic [7:0] s;
    s = 8'h00;
    for (int k = 4; k < 8; k++) s = ref_misr(s, rc[k]);
    return s;
  endfunction

  task automatic run_a(output int done_at, output logic [7:0] sig_done);
    logic [7:0] exp;
    bit         seen [0:255];
    int         dups;
    done_at = -1; sig_done = 8'h00; exp = 8'h01; dups = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    start_a = 1'b1; resp_a = ra[0];
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      resp_a = ra[k];
      if (k <= 255) begin
        checks++;
        if (sv_a !== 1'b1 || stim_a !== exp) begin
          errors++;
          $display("FAIL stim_seq k=%0d: got valid=%b stim=%h, want valid=1 stim=%h", k, sv_a, stim_a, exp);
        end
        if (seen[stim_a]) dups++;
        seen[stim_a] = 1'b1;
        exp = ref_lfsr(exp);
      end
      if (k <= 6) begin
        checks++;
        if (stim_a !== known[k-1]) begin
          errors++;
          $display("FAIL stim_known k=%0d: got %h, want %h", k, stim_a, known[k-1]);
        end
      end
      if (k == 256) begin
        checks++;
        if ({sv_a, stim_a, busy_a, done_a} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL flush_a: got valid=%b stim=%h busy=%b done=%b, want 0 00 1 0", sv_a, stim_a, busy_a, done_a);
        end
      end
      if (done_a === 1'b1) begin
        done_at = k; sig_done = sig_a;
        break;
      end
      tick();
    end
    checks++;
    if (dups != 0 || seen[0]) begin
      errors++;
      $display("FAIL lfsr_period: got %0d repeats (zero seen=%b), want 0 repeats", dups, seen[0]);
    end
  endtask

  task automatic run_c(input bit poke_start, output int done_at, output logic [7:0] sig_done,
                       output logic pass_done);
    done_at = -1; sig_done = 8'h00; pass_done = 1'b0;
    start_c = 1'b1; resp_c = rc[0];
    tick();
    start_c = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      resp_c  = rc[k];
      start_c = poke_start && (k == 2);
      if (k == 4) begin
        checks++;
        if (sig_c !== 8'h00) begin
          errors++;
          $display("FAIL cap_early: got sig=%h at t+4, want 00", sig_c);
        end
      end
      if (k == 5) begin
        checks++;
        if (sig_c !== ref_misr(8'h00, rc[4])) begin
          errors++;
          $display("FAIL cap_first: got sig=%h at t+5, want %h", sig_c, ref_misr(8'h00, rc[4]));
        end
      end
      if (done_c === 1'b1) begin
        done_at = k; sig_done = sig_c; pass_done = pass_c;
        break;
      end
      tick();
    end
    start_c = 1'b0;
  endtask

  task automatic check_c_run(input string name, input int done_at, input logic [7:0] got);
    checks++;
    if (done_at != 8 || got !== model_c()) begin
      errors++;
      $display("FAIL %s: got done_at=t+%0d sig=%h, want t+8 sig=%h", name, done_at, got, model_c());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_abort = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    resp_a = 8'h00; resp_b = 8'h00; resp_c = 8'h00;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({stim_a, sv_a, busy_a, done_a, sig_a, pass_a,
           stim_b, sv_b, busy_b, done_b, sig_b, pass_b,
           stim_c, sv_c, busy_c, done_c, sig_c, pass_c} !== 60'h0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got a=%h/%b%b%b/%h b=%h/%b%b%b/%h c=%h/%b%b%b/%h, want all 0", i,
                 stim_a, sv_a, busy_a, done_a, sig_a, stim_b, sv_b, busy_b, done_b, sig_b,
                 stim_c, sv_c, busy_c, done_c, sig_c);
      end
    end
  endtask

  task automatic test_sequence();
    int         d;
    logic [7:0] s, exp_sig;
    for (int k = 0; k <= 300; k++) ra[k] = 8'($urandom);
    exp_sig = 8'h00;
    for (int k = 2; k <= 256; k++) exp_sig = ref_misr(exp_sig, ra[k]);
    run_a(d, s);
    checks++;
    if (d != 257 || s !== exp_sig) begin
      errors++;
      $display("FAIL run_a: got done_at=t+%0d sig=%h, want t+257 sig=%h", d, s, exp_sig);
    end
    for (int i = 0; i < 3; i++) begin
      resp_a = 8'($urandom);
      tick();
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || sig_a !== exp_sig) begin
        errors++;
        $display("FAIL done_hold: got done=%b busy=%b sig=%h, want 1 0 %h", done_a, busy_a, sig_a, exp_sig);
      end
    end
    run_a(d, s);
    checks++;
    if (d != 257 || s !== exp_sig) begin
      errors++;
      $display("FAIL rerun_a: got done_at=t+%0d sig=%h, want t+257 sig=%h", d, s, exp_sig);
    end
  endtask

  task automatic test_compaction();
    logic [7:0] v0, v1;
    for (int r = 0; r < 3; r++) begin
      v0 = (r == 0) ? 8'hFF : 8'($urandom);
      v1 = (r == 0) ? 8'hFF : 8'($urandom);
      start_b = 1'b1;
      tick();
      start_b = 1'b0; resp_b = v0;
      checks++;
      if (sv_b !== 1'b1 || stim_b !== 8'h01 || sig_b !== 8'h00) begin
        errors++;
        $display("FAIL comp_c1 run %0d: got valid=%b stim=%h sig=%h, want 1 01 00", r, sv_b, stim_b, sig_b);
      end
      tick();
      resp_b = v1;
      checks++;
      if (stim_b !== 8'h02 || sig_b !== ref_misr(8'h00, v0)) begin
        errors++;
        $display("FAIL comp_c2 run %0d: got stim=%h sig=%h, want 02 %h", r, stim_b, sig_b, ref_misr(8'h00, v0));
      end
      tick();
      checks++;
      if (done_b !== 1'b1 || busy_b !== 1'b0 || sv_b !== 1'b0 ||
          sig_b !== ref_misr(ref_misr(8'h00, v0), v1) || (r == 0 && sig_b !== 8'h1C)) begin
        errors++;
        $display("FAIL comp_done run %0d: got done=%b busy=%b sig=%h, want 1 0 %h", r, done_b, busy_b, sig_b,
                 ref_misr(ref_misr(8'h00, v0), v1));
      end
    end
  endtask

  task automatic test_latency();
    int         d;
    logic [7:0] s;
    logic       p;
    for (int k = 0; k < 32; k++) rc[k] = 8'($urandom);
    run_c(1'b0, d, s, p);
    check_c_run("latency", d, s);
  endtask

  task automatic test_boundary();
    int         d;
    logic [7:0] s;
    logic       p;
    for (int k = 0; k < 32; k++) rc[k] = 8'($urandom);
    run_c(1'b1, d, s, p);
    check_c_run("start_in_run", d, s);
    start_c = 1'b1; resp_c = rc[0];
    tick();
    start_c = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      resp_c = rc[k];
      tick();
    end
    resp_c = rc[5];
    checks++;
    if (busy_c !== 1'b1 || sv_c !== 1'b0 || done_c !== 1'b0) begin
      errors++;
      $display("FAIL in_flush: got busy=%b valid=%b done=%b, want 1 0 0", busy_c, sv_c, done_c);
    end
    rst_abort = 1'b1;
    tick();
    rst_abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy_c, done_c, sv_c, stim_c, sig_c} !== 19'h0) begin
        errors++;
        $display("FAIL abort %0d: got busy=%b done=%b valid=%b stim=%h sig=%h, want all 0", i,
                 busy_c, done_c, sv_c, stim_c, sig_c);
      end
      tick();
    end
    run_c(1'b0, d, s, p);
    check_c_run("after_abort", d, s);
    run_c(1'b0, d, s, p);
    check_c_run("from_done", d, s);
  endtask

  task automatic test_compare();
    int         d;
    logic [7:0] s;
    logic       p;
    for (int k = 0; k < 32; k++) rc[k] = fixed_resp(k);
    run_c(1'b0, d, s, p);
    check_c_run("golden_run", d, s);
    checks++;
`ifdef DROPS_BIST_COMPARE_EN
    if (p !== 1'b1 || s !== GOLD_C) begin
      errors++;
      $display("FAIL pass_match: got pass=%b sig=%h, want pass=1 sig=%h", p, s, GOLD_C);
    end
`else
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL pass_tied: got pass=%b, want 0", p);
    end
`endif
    rc[5] = rc[5] ^ 8'h04;
    run_c(1'b0, d, s, p);
    check_c_run("flipped_run", d, s);
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL pass_flip: got pass=%b, want 0", p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequence();
    test_compaction();
    test_latency();
    test_boundary();
    test_compare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drops_bist.md
# drops_bist

Parametrised on-chip built-in self-test harness for the drops design. It is a synthesizable successor to the cocotb bench wiring, generalised in stimulus and response width. An LFSR drives pseudo-random vectors into the core's inputs, and a MISR compacts the core's outputs into a signature. The block sits between the `tt_um_drops` pad-facing ports and the user core, so the chip can be checked without an external tester.

## Interface
- `W_IN`, 8: stimulus width; legal range 4..16.
- `W_OUT`, 8: response width; legal range 4..16.
- `N_VEC`, 255: number of stimulus vectors per run; range 1..65535.
- `LAT`, 1: core latency from stimulus to response, in cycles; range 0..7.
- `SEED`, 1: initial stimulus LFSR state; a value of 0 is replaced by 1.
- `GOLDEN`, 0: expected signature, used only when the compare feature is compiled in.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a run.
- `resp_i` in `W_OUT`: core outputs, sampled under the capture window.
- `stim_o` out `W_IN`: stimulus to the core; 0 whenever not in RUN.
- `stim_valid` out 1: high during the RUN state.
- `busy` out 1: high in RUN or FLUSH.
- `done` out 1: high in DONE; held until the next start or reset.
- `signature` out `W_OUT`: MISR contents.
- `pass` out 1: `signature == GOLDEN` while `done` (compare feature only).

## Operation
- States are IDLE, RUN, FLUSH and DONE. Reset puts the block in IDLE with every output 0, the MISR at 0, the LFSR at SEED and the counter at 0.
- IDLE or DONE, with `start`: go to RUN. On the same edge the MISR is cleared, the LFSR is loaded with SEED and the counter is cleared.
- `start` is ignored in RUN and FLUSH.
- RUN:
  - `stim_o` is the LFSR state.
  - The LFSR advances every cycle as a Fibonacci register: next = {s[W_IN-2:0], ^(s & TAPS[W_IN])}.
  - Leave RUN after N_VEC cycles. Go to FLUSH if LAT > 0, otherwise to DONE.
- FLUSH lasts exactly LAT cycles, then goes to DONE.
- Capture window:
  - `cap` = `stim_valid` delayed by LAT cycles through a shift register. With LAT = 0, `cap` equals `stim_valid`.
  - While `cap` is high, the MISR updates as sig = {sig[W_OUT-2:0],1'b0} ^ (sig[W_OUT-1] ? POLY[W_OUT] : 0) ^ `resp_i`.
  - Exactly N_VEC responses are compacted per run.
- The LFSR is maximal-length, with period 2^W_IN − 1. When N_VEC is at or above the period, the sequence wraps to SEED with no special handling.
- The counter is 16 bits and compares against N_VEC − 1. No overflow is possible.
- A `rst` asserted mid-run aborts the run: the block is in IDLE on the next cycle, the capture pipe is cleared and nothing is retained.

## Timing
- `start` sampled at edge t: `stim_valid` = 1 and `stim_o` = SEED from t+1 through t+N_VEC.
- `done` = 1 from t+N_VEC+LAT+1.
- `signature` is registered. Its final value is valid on the same cycle `done` rises.
- `pass` is combinational from `signature` and `done`.

## Configuration
- Macro: `DROPS_BIST_COMPARE_EN`.
- Defined: the GOLDEN comparator and `pass` are generated as described above.
- Undefined:
  - `pass` is tied to 0 and the comparator logic is absent.
  - The GOLDEN parameter is accepted but unused.
  - The signature is read out through `signature` only.

## Structure
- Package `drops_bist_pkg` holds:
  - the state enum `bist_state_t`;
  - the function `lfsr_taps(w)`, a table for widths 4..16 with 8 → 0xB8;
  - the function `misr_poly(w)`, with 8 → 0x1D.
- One sub-module, `drops_bist_misr`. It is parametrised on width and has ports `clk`, `rst`, `clr`, `en`, `d` and `q`.
- The FSM, counter, LFSR and capture pipe live in the top module.

## Test plan
- Reset check: hold `rst` for 2 cycles, then release → every output is 0, state is IDLE, and `stim_o` stays 0 with no `start`.
- Sequence check: W_IN = 8, SEED = 1, pulse `start` → `stim_o` reads 0x01, 0x02, 0x04, 0x08, 0x11, 0x23 on consecutive cycles. With N_VEC = 255, vector 256 would be 0x01 again.
- Compaction check: LAT = 0, N_VEC = 2, `resp_i` held at 0xFF → `signature` is 0xFF after the first capture and 0x1C at `done`.
- Latency check: LAT = 3, N_VEC = 4 → `done` rises 8 cycles after the `start` edge, and exactly 4 captures occur, the first on cycle t+4.
- Boundary check: pulse `start` again during RUN → it is ignored. Assert `rst` during FLUSH → the block is in IDLE next cycle with the signature at 0. A fresh `start` from DONE reproduces an identical signature.
- Compare check, with `DROPS_BIST_COMPARE_EN` defined: set GOLDEN to the signature from the previous run → `pass` = 1. Flip one bit of `resp_i` on one cycle → `pass` = 0.
